// File: rtl/ntt_addr_seq_pkg.sv
// Shared constants and FSM state type for the 8-point NTT address sequencer.
package ntt_addr_seq_pkg;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_e;

endpackage

// File: rtl/ntt_stage_cnt.sv
// Per-stage butterfly counter: j, jmod and tprev, updated incrementally
// so no divider or multiplier is needed.
module ntt_stage_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         adv_i,
    input  logic [W-1:0] t_i,
    output logic [W-1:0] j_o,
    output logic [W-1:0] jmod_o,
    output logic [W-1:0] tprev_o,
    output logic [W-1:0] jmod_nxt_o
);

    logic [W-1:0] j_q, j_d;
    logic [W-1:0] jmod_q, jmod_d;
    logic [W-1:0] tprev_q, tprev_d;

    // When jmod wraps at t-1 the next butterfly belongs to the following group.
    always_comb begin
        j_d     = j_q;
        jmod_d  = jmod_q;
        tprev_d = tprev_q;
        if (clr_i) begin
            j_d     = '0;
            jmod_d  = '0;
            tprev_d = '0;
        end else if (adv_i) begin
            j_d = j_q + W'(1);
            if (jmod_q == t_i - W'(1)) begin
                jmod_d  = '0;
                tprev_d = tprev_q + (t_i << 1);
            end else begin
                jmod_d = jmod_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q     <= '0;
            jmod_q  <= '0;
            tprev_q <= '0;
        end else begin
            j_q     <= j_d;
            jmod_q  <= jmod_d;
            tprev_q <= tprev_d;
        end
    end

    assign j_o        = j_q;
    assign jmod_o     = jmod_q;
    assign tprev_o    = tprev_q;
    assign jmod_nxt_o = jmod_d;

endmodule

// File: rtl/ntt_addr_seq.sv
// Cooley-Tukey stage/butterfly loop sequencer feeding the NTT index and
// twiddle generators, with a programmable drain gap between stages.
module ntt_addr_seq
    import ntt_addr_seq_pkg::*;
#(
    parameter int N         = ntt_addr_seq_pkg::N,
    parameter int LOGN      = ntt_addr_seq_pkg::LOGN,
    parameter int W         = ntt_addr_seq_pkg::W,
    parameter int STAGE_GAP = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         hold,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic [W-1:0] t,
    output logic [W-1:0] jmod,
    output logic [W-1:0] tprev,
    output logic [W-1:0] tw_exp,
    output logic         stage_first
);

    localparam logic [W-1:0] LAST_J   = W'(N / 2 - 1);
    localparam logic [W-1:0] LAST_I   = W'(LOGN);
    localparam logic [W-1:0] GAP_LOAD = (STAGE_GAP > 0) ? W'(STAGE_GAP - 1) : '0;

    state_e       state_q, state_d;
    logic [W-1:0] gap_q, gap_d;
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] t_q, t_d;
    logic [W-1:0] tw_q, tw_d;
    logic         valid_q, valid_d;
    logic         sf_q, sf_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         cntClr, cntAdv, loadNext;
    logic [W-1:0] jCnt, jmodCnt, tprevCnt, jmodNxt;

    ntt_stage_cnt #(.W(W)) u_stage_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cntClr),
        .adv_i      (cntAdv),
        .t_i        (t_q),
        .j_o        (jCnt),
        .jmod_o     (jmodCnt),
        .tprev_o    (tprevCnt),
        .jmod_nxt_o (jmodNxt)
    );

    // Registers default to holding, which is exactly what hold=1 needs.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        i_d      = i_q;
        t_d      = t_q;
        tw_d     = tw_q;
        valid_d  = valid_q;
        sf_d     = sf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cntClr   = 1'b0;
        cntAdv   = 1'b0;
        loadNext = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    i_d     = W'(1);
                    t_d     = W'(N / 2);
                    tw_d    = '0;
                    sf_d    = 1'b1;
                    cntClr  = 1'b1;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (jCnt != LAST_J) begin
                        cntAdv = 1'b1;
                        tw_d   = jmodNxt << (i_q - W'(1));
                        sf_d   = 1'b0;
                    end else if (i_q < LAST_I) begin
                        if (STAGE_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                            valid_d = 1'b0;
                            sf_d    = 1'b0;
                        end else begin
                            loadNext = 1'b1;
                        end
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        sf_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!hold) begin
                    if (gap_q == '0) begin
                        loadNext = 1'b1;
                    end else begin
                        gap_d = gap_q - W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Shared entry into the next stage, from RUN (no gap) or from GAP.
        if (loadNext) begin
            state_d = RUN;
            valid_d = 1'b1;
            i_d     = i_q + W'(1);
            t_d     = t_q >> 1;
            tw_d    = '0;
            sf_d    = 1'b1;
            cntClr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            i_q     <= '0;
            t_q     <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            sf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            i_q     <= i_d;
            t_q     <= t_d;
            tw_q    <= tw_d;
            valid_q <= valid_d;
            sf_q    <= sf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign valid       = valid_q;
    assign i           = i_q;
    assign j           = jCnt;
    assign t           = t_q;
    assign jmod        = jmodCnt;
    assign tprev       = tprevCnt;
    assign tw_exp      = tw_q;
    assign stage_first = sf_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Bench for ntt_addr_seq: two instances (STAGE_GAP=2 and 0) compared every
// cycle against a schedule-table model, plus directed latency/hold/reset cases.
module tb_ntt_addr_seq;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;

    logic [1:0]   busyO, doneO, validO, sfO;
    logic [W-1:0] iO[2], jO[2], tO[2], jmodO[2], tprevO[2], twO[2];

    typedef struct {
        bit v;
        bit sf;
        bit dn;
        int i;
        int j;
        int t;
        int jm;
        int tp;
        int tw;
    } ent_t;

    ent_t sched[2][32];
    int   schedLen[2];
    int   idx[2] = '{-1, -1};
    bit   zero[2] = '{1'b1, 1'b1};
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ntt_addr_seq #(.N(8), .LOGN(3), .W(W), .STAGE_GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .busy(busyO[0]), .done(doneO[0]), .valid(validO[0]),
        .i(iO[0]), .j(jO[0]), .t(tO[0]), .jmod(jmodO[0]), .tprev(tprevO[0]),
        .tw_exp(twO[0]), .stage_first(sfO[0])
    );

    ntt_addr_seq #(.N(8), .LOGN(3), .W(W), .STAGE_GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .busy(busyO[1]), .done(doneO[1]), .valid(validO[1]),
        .i(iO[1]), .j(jO[1]), .t(tO[1]), .jmod(jmodO[1]), .tprev(tprevO[1]),
        .tw_exp(twO[1]), .stage_first(sfO[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // The whole busy period as a flat list of per-cycle expectations.
    function automatic void buildSched();
        for (int k = 0; k < 2; k++) begin
            int   g;
            int   n;
            ent_t e;
            g = (k == 0) ? 2 : 0;
            n = 0;
            for (int s = 1; s <= 3; s++) begin
                for (int jj = 0; jj < 4; jj++) begin
                    e.v  = 1'b1;
                    e.sf = (jj == 0);
                    e.dn = 1'b0;
                    e.i  = s;
                    e.j  = jj;
                    e.t  = 8 >> s;
                    e.jm = jj % e.t;
                    e.tp = 2 * e.t * (jj / e.t);
                    e.tw = e.jm << (s - 1);
                    sched[k][n] = e;
                    n++;
                end
                if (s < 3) begin
                    for (int q = 0; q < g; q++) begin
                        e = '{default: 0};
                        sched[k][n] = e;
                        n++;
                    end
                end
            end
            e = '{default: 0};
            e.dn = 1'b1;
            sched[k][n] = e;
            schedLen[k] = n + 1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                idx[k]  <= -1;
                zero[k] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (idx[k] < 0) begin
                    if (start) begin
                        idx[k]  <= 0;
                        zero[k] <= 1'b0;
                    end
                end else if (sched[k][idx[k]].dn) begin
                    idx[k] <= -1;
                end else if (!hold) begin
                    idx[k] <= idx[k] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input int k);
        ent_t e;
        if (idx[k] < 0) begin
            chk("busy", k, busyO[k], 0);
            chk("done", k, doneO[k], 0);
            chk("valid", k, validO[k], 0);
            chk("stage_first", k, sfO[k], 0);
            if (zero[k]) begin
                chk("i", k, iO[k], 0);
                chk("j", k, jO[k], 0);
                chk("t", k, tO[k], 0);
                chk("jmod", k, jmodO[k], 0);
                chk("tprev", k, tprevO[k], 0);
                chk("tw_exp", k, twO[k], 0);
            end
        end else begin
            e = sched[k][idx[k]];
            chk("busy", k, busyO[k], 1);
            chk("done", k, doneO[k], e.dn);
            chk("valid", k, validO[k], e.v);
            chk("stage_first", k, sfO[k], e.sf);
            if (e.v) begin
                chk("i", k, iO[k], e.i);
                chk("j", k, jO[k], e.j);
                chk("t", k, tO[k], e.t);
                chk("jmod", k, jmodO[k], e.jm);
                chk("tprev", k, tprevO[k], e.tp);
                chk("tw_exp", k, twO[k], e.tw);
            end
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    task automatic applyStimulus(output int d0, output int d1, output int v0, output int v1,
                                 output int sfm, output int fv0);
        d0 = 0; d1 = 0; v0 = 0; v1 = 0; sfm = 0; fv0 = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (validO[0]) begin
                v0++;
                if (fv0 == 0) fv0 = c;
            end
            if (validO[1]) v1++;
            if (sfO[1] && c < 32) sfm |= (1 << c);
            if (doneO[0] && d0 == 0) d0 = c;
            if (doneO[1] && d1 == 0) d1 = c;
            if (d0 != 0 && d1 != 0) break;
        end
    endtask

    initial begin
        int d0, d1, v0, v1, sfm, fv0;
        int hA, hB, dH, rep, dc;

        buildSched();
        chk("modelLen", 0, schedLen[0], 17);
        chk("modelLen", 1, schedLen[1], 13);
        chk("model_i", 0, sched[0][8].i, 2);
        chk("model_jmod", 0, sched[0][8].jm, 0);
        chk("model_tprev", 0, sched[0][8].tp, 4);
        chk("model_tw", 0, sched[0][7].tw, 2);
        chk("model_gap", 0, sched[0][4].v, 0);
        chk("model_tprev", 1, sched[1][11].tp, 6);

        #2;
        chk("rstBusy", 0, busyO[0], 0);
        chk("rstValid", 0, validO[0], 0);
        chk("rstTprev", 0, tprevO[0], 0);
        #10 rst_n = 1'b1;

        // Plain run on both instances.
        applyStimulus(d0, d1, v0, v1, sfm, fv0);
        chk("firstValid", 0, fv0, 1);
        chk("doneLatency", 0, d0, 17);
        chk("doneLatency", 1, d1, 13);
        chk("validCount", 0, v0, 12);
        chk("validCount", 1, v1, 12);
        chk("stageFirstMask", 1, sfm, 32'h222);
        repeat (3) @(posedge clk);

        // Hold on tuple (2,2,0,4,0) for 3 cycles, then 2 cycles in the second gap.
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        hA = 0; hB = 0; dH = 0; rep = 0;
        for (int c = 1; c <= 80; c++) begin
            if (validO[0] && iO[0] == 2 && jO[0] == 2 && jmodO[0] == 0 && tprevO[0] == 4 && twO[0] == 0)
                rep++;
            if (doneO[0]) begin
                dH = c;
                break;
            end
            if (idx[0] == 8 && hA < 3) begin
                hold = 1'b1;
                hA++;
            end else if (idx[0] == 10 && hB < 2) begin
                hold = 1'b1;
                hB++;
            end else begin
                hold = 1'b0;
            end
            @(posedge clk); #2;
        end
        hold = 1'b0;
        chk("holdDoneLatency", 0, dH, 22);
        chk("holdRepeat", 0, rep, 4);
        repeat (3) @(posedge clk);

        // Start mid-run and in the DONE cycle are ignored; the next one is taken.
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 5);
            if (doneO[0]) begin
                dc = c;
                break;
            end
            @(posedge clk); #2;
        end
        chk("ignoreMidStart", 0, dc, 17);
        start = 1'b1;
        @(posedge clk); #2;
        chk("doneStartIgnored", 0, busyO[0], 0);
        @(posedge clk); #2 start = 1'b0;
        chk("restartValid", 0, validO[0], 1);
        chk("restart_i", 0, iO[0], 1);
        chk("restart_j", 0, jO[0], 0);
        chk("restart_t", 0, tO[0], 4);
        chk("restart_sf", 0, sfO[0], 1);

        // Asynchronous reset during stage 2 of the new transform.
        for (int c = 0; c < 40 && idx[0] != 7; c++) begin
            @(posedge clk); #2;
        end
        chk("reachStage2", 0, idx[0], 7);
        #1 rst_n = 1'b0;
        #1;
        chk("asyncBusy", 0, busyO[0], 0);
        chk("asyncDone", 0, doneO[0], 0);
        chk("asyncValid", 0, validO[0], 0);
        chk("async_i", 0, iO[0], 0);
        chk("async_j", 0, jO[0], 0);
        chk("async_jmod", 0, jmodO[0], 0);
        chk("async_tw", 0, twO[0], 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(d0, d1, v0, v1, sfm, fv0);
        chk("postRstLatency", 0, d0, 17);
        chk("postRstLatency", 1, d1, 13);
        chk("postRstValid", 0, v0, 12);

        // Random start/hold traffic with occasional asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            start = ($urandom % 6 == 0);
            hold  = ($urandom % 4 == 0);
            if ($urandom % 150 == 0) begin
                rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        hold = 1'b0;
        repeat (30) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_addr_seq.md
Name: ntt_addr_seq

Overview:
- Loop/address sequencer that sits directly upstream of the butterfly index generator in the 8-point NTT processor.
- Walks the Cooley-Tukey stage loop (stage i, butterfly j) once per transform and emits, per butterfly, the operand set the index generator consumes: j, t, i, jmod and tprev.
- Also emits the twiddle exponent consumed by the on-the-fly twiddle generator.
- Inserts a programmable drain gap between stages so the butterfly pipeline can write back before the next stage reads.

Parameters:
- N, 8, transform length (power of two).
- LOGN, 3, log2(N), i.e. the number of stages.
- W, 5, width of every index/counter output.
- STAGE_GAP, 2, idle cycles inserted between consecutive stages (0 allowed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a transform; honoured only in IDLE.
- hold  input  1  downstream stall; freezes the sequencer and all outputs.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse after the last butterfly of the last stage is accepted.
- valid  output  1  the operand outputs describe a live butterfly.
- i  output  W  stage number, 1..LOGN.
- j  output  W  butterfly counter within the stage, 0..N/2-1.
- t  output  W  half-span, N >> i.
- jmod  output  W  j mod t.
- tprev  output  W  group base address, 2*t*floor(j/t).
- tw_exp  output  W  twiddle exponent, jmod << (i-1).
- stage_first  output  1  high with the j=0 butterfly of each stage (twiddle generator reseed).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, valid and stage_first are 0; i, j, t, jmod, tprev and tw_exp are 0. Reset asserted mid-transform aborts immediately; no done is produced.
- All outputs are registered. No division or multiplication:
  - jmod and tprev update incrementally: jmod+1; on jmod==t-1, jmod=0 and tprev+=2t.
  - t is a right shift; tw_exp is a shift.
- FSM states:
  - IDLE:
    - start=1 -> RUN. Next cycle: valid=1, i=1, j=0, t=N/2, jmod=0, tprev=0, tw_exp=0, stage_first=1.
  - RUN (advances only when hold=0; the butterfly is consumed when valid&~hold):
    - j<N/2-1: j+1; update jmod, tprev and tw_exp; stage_first=0.
    - j==N/2-1, i<LOGN, STAGE_GAP>0: valid=0 -> GAP, gap counter=STAGE_GAP-1.
    - j==N/2-1, i<LOGN, STAGE_GAP==0: go directly to the next stage with valid=1: i+1, t>>1, j, jmod and tprev cleared, stage_first=1.
    - j==N/2-1, i==LOGN: valid=0 -> DONE.
  - GAP:
    - Counts down while hold=0.
    - At 0 -> RUN, loading the next stage as above (valid=1, stage_first=1).
  - DONE:
    - done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
    - hold is ignored in DONE.
- hold=1 in RUN or GAP: every register, including the gap counter and all outputs, keeps its value.
- Start while not in IDLE is ignored. Start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- Latency with hold=0: first valid 1 cycle after start. Valid cycles = LOGN*N/2 = 12. Total busy cycles = 12 + (LOGN-1)*STAGE_GAP + 1 = 17 for the defaults.
- Expected sequence for N=8, reading (i, j, jmod, tprev, tw_exp):
  - Stage 1: (1,0,0,0,0) (1,1,1,0,1) (1,2,2,0,2) (1,3,3,0,3).
  - Stage 2: (2,0,0,0,0) (2,1,1,0,2) (2,2,0,4,0) (2,3,1,4,2).
  - Stage 3: (3,0,0,0,0) (3,1,0,2,0) (3,2,0,4,0) (3,3,0,6,0).
- Widths: all arithmetic is modulo 2^W. N<=2^(W-1) is guaranteed by parameter choice, so nothing wraps in normal operation.

Decomposition:
- The shared NTT package holds:
  - constants N, LOGN, W;
  - the FSM state enum (IDLE, RUN, GAP, DONE).
- One natural sub-module, ntt_stage_cnt: holds j, jmod and tprev with the incremental update, plus its clear/load-next-stage controls.
- The FSM and the gap counter stay in ntt_addr_seq.

Test Plan:
- Reset then start with hold=0, STAGE_GAP=2:
  - valid rises 1 cycle after start.
  - The 12 tuples match the table above exactly.
  - Two valid=0 cycles after the stage-1 and stage-2 tuples.
  - done pulses 17 cycles after start, and busy drops with it.
- STAGE_GAP=0: the 12 valid cycles are back-to-back, stage_first is high on cycles 1, 5 and 9, and done comes 13 cycles after start.
- hold=1 for 3 cycles on tuple (2,2,0,4,0), then hold=1 for 2 cycles during a GAP:
  - The outputs are frozen and the tuple is repeated.
  - The sequence resumes unchanged.
  - done is delayed by 5 cycles.
- start pulsed mid-run, in the DONE cycle, and one cycle later:
  - The first two have no effect.
  - The third starts a new transform at (1,0,0,0,0).
- rst_n dropped asynchronously during stage 2:
  - All outputs go to 0 immediately, with no done.
  - After release, start yields the full correct sequence.
